output_pkt_reader: RTL and testbench

- Drains packets from a first-word-fall-through synchronous FIFO (read side: dout/rd_en/empty) and presents them downstream as a valid/ready beat stream with sop/eop framing.
- Packet format in the FIFO: one header word, followed by N payload words. N is carried in header bits [LEN_WIDTH-1:0].
- Sits between a port FIFO and the output arbiter/crossbar of the multi-port cache.
- A 2-entry output buffer keeps fifo_rd_en free of any combinational path from out_ready.

---
 rtl/output_pkt_reader.sv | 168 ++++++++++++++++
 tb/tb_output_pkt_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_pkt_reader.sv
// Packet reader: drains header+payload packets from a first-word-fall-through
// FIFO and presents them as a valid/ready beat stream with sop/eop framing.
// A 2-entry output buffer decouples the FIFO pop strobe from out_ready, so
// fifo_rd_en depends only on registered state plus the FIFO flag and en.
module output_pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,   // next FIFO word is a header
        BODY = 1'b1    // next FIFO word is payload
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [LEN_WIDTH-1:0]   rem_r;
    logic [LEN_WIDTH-1:0]   rem_next_s;
    logic [LEN_WIDTH-1:0]   hdr_len_s;

    // Output buffer storage: two entries of {data, sop, eop}
    logic [DATA_WIDTH-1:0]  buf_data_r [0:1];
    logic [1:0]             buf_sop_r;
    logic [1:0]             buf_eop_r;
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;
    logic [1:0]             count_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   push_sop_s;
    logic                   push_eop_s;
    logic [CNT_WIDTH-1:0]   pkt_cnt_r;

    assign hdr_len_s = fifo_dout[LEN_WIDTH-1:0];

    // Pop only from registered state, the FIFO flag and en; out_ready never
    // reaches this path. Held off while reset is asserted.
    assign fifo_rd_en = rst_n & ~fifo_empty & (count_r != 2'd2) &
                        ((state_r == BODY) | en);
    assign push_s     = fifo_rd_en;
    assign pop_s      = out_valid & out_ready;

    assign out_valid  = (count_r != 2'd0);
    assign out_data   = out_valid ? buf_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign out_sop    = out_valid & buf_sop_r[rd_ptr_r];
    assign out_eop    = out_valid & buf_eop_r[rd_ptr_r];
    assign busy       = (state_r == BODY) | (count_r != 2'd0);
    assign pkt_cnt    = pkt_cnt_r;

    // Framing state register and remaining-payload counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rem_r   <= LEN_ZERO;
        end else begin
            state_r <= state_next_s;
            rem_r   <= rem_next_s;
        end
    end

    // Next-state and beat tagging for the word being popped this cycle
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = rem_r;
        push_sop_s   = 1'b0;
        push_eop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                push_sop_s = 1'b1;
                if (hdr_len_s == LEN_ZERO) begin
                    push_eop_s = 1'b1;
                end else begin
                    push_eop_s = 1'b0;
                end
                if (fifo_rd_en && (hdr_len_s != LEN_ZERO)) begin
                    rem_next_s   = hdr_len_s;
                    state_next_s = BODY;
                end else begin
                    rem_next_s   = rem_r;
                    state_next_s = IDLE;
                end
            end
            BODY: begin
                push_sop_s = 1'b0;
                if (rem_r == LEN_ONE) begin
                    push_eop_s = 1'b1;
                end else begin
                    push_eop_s = 1'b0;
                end
                if (fifo_rd_en) begin
                    rem_next_s = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = BODY;
                    end
                end else begin
                    rem_next_s   = rem_r;
                    state_next_s = BODY;
                end
            end
            default: begin
                state_next_s = IDLE;
                rem_next_s   = LEN_ZERO;
            end
        endcase
    end

    // Output buffer: write popped words at the tail, retire accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_r[0] <= {DATA_WIDTH{1'b0}};
            buf_data_r[1] <= {DATA_WIDTH{1'b0}};
            buf_sop_r     <= 2'b00;
            buf_eop_r     <= 2'b00;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= fifo_dout;
                buf_sop_r[wr_ptr_r]  <= push_sop_s;
                buf_eop_r[wr_ptr_r]  <= push_eop_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Completed-packet counter, bumped when the eop beat is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s && out_eop) begin
            pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

endmodule

// File: tb/tb_output_pkt_reader.sv
// Bench for output_pkt_reader: a queue-based FIFO model feeds the DUT and a
// packet-level scoreboard predicts every beat, the pop strobe, busy and the
// packet count. Directed table vectors, hand-written corner sequences and a
// randomized phase all run against the same reference.
module tb_output_pkt_reader;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  fifo_dout = 8'h00;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic           en = 1'b1;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           out_sop;
    logic           out_eop;
    logic           out_ready = 1'b1;
    logic           busy;
    logic [CW-1:0]  pkt_cnt;

    output_pkt_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .en(en),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
        .out_eop(out_eop), .out_ready(out_ready),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: FIFO contents, expected beat stream, progress indices
    logic [7:0]  fq[$];
    logic [9:0]  exp_q[$];      // {data, sop, eop} in FIFO order
    int          pop_idx = 0;
    int          acc_idx = 0;
    logic [15:0] pkt_exp = 16'd0;
    logic        hold = 1'b0;

    typedef struct {
        logic       rdy;
        logic       en;
        logic       rd;
        logic       vld;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       busy;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = hold || (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push_word(input logic [7:0] w, input logic s, input logic e);
        fq.push_back(w);
        exp_q.push_back({w, s, e});
    endtask

    task automatic push_pkt(input int len);
        logic [7:0] h;
        h = 8'($urandom());
        h[3:0] = 4'(len);
        push_word(h, 1'b1, len == 0);
        for (int k = 0; k < len; k++) push_word(8'($urandom()), 1'b0, k == len - 1);
    endtask

    // Sample on the falling edge and compare against the packet-level model
    task automatic sample();
        int   occ;
        logic in_body;
        logic exp_rd;
        @(negedge clk);
        occ     = pop_idx - acc_idx;
        in_body = (pop_idx > 0) && (pop_idx <= exp_q.size()) && !exp_q[pop_idx-1][0];
        exp_rd  = !fifo_empty && (occ != 2) && (in_body || en);
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        chk("out_valid", {31'd0, out_valid}, {31'd0, occ != 0});
        if (out_valid && acc_idx < exp_q.size())
            chk("beat", {22'd0, out_data, out_sop, out_eop}, {22'd0, exp_q[acc_idx]});
        chk("busy", {31'd0, busy}, {31'd0, in_body || occ != 0});
        chk("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, pkt_exp});
    endtask

    // Apply the consequences of this cycle at the clock edge
    task automatic advance();
        if (fifo_rd_en && fq.size() != 0) begin
            fq.delete(0);
            pop_idx++;
        end
        if (out_valid && out_ready) begin
            if (acc_idx < exp_q.size() && exp_q[acc_idx][0]) pkt_exp = pkt_exp + 16'd1;
            acc_idx++;
        end
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            advance();
        end
    endtask

    task automatic drain(input string name);
        int guard;
        hold = 1'b0; en = 1'b1; out_ready = 1'b1;
        refresh();
        guard = 0;
        while (acc_idx < exp_q.size() && guard < 600) begin
            tick(1);
            guard++;
        end
        chk(name, acc_idx, exp_q.size());
    endtask

    initial begin
        int base;
        // Basic packet 03,A1,A2,A3 then header-only 00 and 01,B0 back to back
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 16'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 16'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd3};

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        push_word(8'h03, 1'b1, 1'b0);
        push_word(8'hA1, 1'b0, 1'b0);
        push_word(8'hA2, 1'b0, 1'b0);
        push_word(8'hA3, 1'b0, 1'b1);
        refresh();

        // Table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            if (i == 6) begin
                push_word(8'h00, 1'b1, 1'b1);
                push_word(8'h01, 1'b1, 1'b0);
                push_word(8'hB0, 1'b0, 1'b1);
                refresh();
            end
            out_ready = tbl[i].rdy;
            en        = tbl[i].en;
            sample();
            chk("tbl_rd_en", {31'd0, fifo_rd_en}, {31'd0, tbl[i].rd});
            chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].vld});
            if (tbl[i].vld)
                chk("tbl_beat", {22'd0, out_data, out_sop, out_eop},
                    {22'd0, tbl[i].data, tbl[i].sop, tbl[i].eop});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
            chk("tbl_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, tbl[i].cnt});
            advance();
        end

        // Backpressure: stall 5 clocks after the first beat appears
        push_word(8'h03, 1'b1, 1'b0);
        push_word(8'hA1, 1'b0, 1'b0);
        push_word(8'hA2, 1'b0, 1'b0);
        push_word(8'hA3, 1'b0, 1'b1);
        refresh();
        tick(1);
        out_ready = 1'b0;
        tick(4);
        sample();
        chk("bp_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
        chk("bp_hold_beat", {22'd0, out_data, out_sop, out_eop}, {22'd0, 8'h03, 1'b1, 1'b0});
        advance();
        base = pkt_exp;
        drain("bp_drain");
        chk("bp_pkt_cnt", {16'd0, pkt_cnt}, base + 1);

        // en gating: idle with a full packet, then drop en mid-body
        en = 1'b0;
        push_word(8'h02, 1'b1, 1'b0);
        push_word(8'hF0, 1'b0, 1'b0);
        push_word(8'hF1, 1'b0, 1'b1);
        push_word(8'h01, 1'b1, 1'b0);
        push_word(8'hF2, 1'b0, 1'b1);
        refresh();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("en_no_pop", {31'd0, fifo_rd_en}, 32'd0);
            chk("en_no_valid", {31'd0, out_valid}, 32'd0);
            advance();
        end
        base = pkt_cnt;
        en = 1'b1;
        tick(2);
        en = 1'b0;
        tick(6);
        chk("en_fifo_left", fq.size(), 2);
        chk("en_pkt_done", {16'd0, pkt_cnt}, base + 1);
        drain("en_drain");

        // FIFO underrun mid-packet
        push_word(8'h02, 1'b1, 1'b0);
        push_word(8'hC0, 1'b0, 1'b0);
        refresh();
        tick(2);
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("gap_busy", {31'd0, busy}, 32'd1);
            advance();
        end
        base = pkt_cnt;
        push_word(8'hC1, 1'b0, 1'b1);
        refresh();
        tick(4);
        chk("gap_pkt_cnt", {16'd0, pkt_cnt}, base + 1);

        // Reset mid-packet after the header and one payload word
        push_word(8'h05, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) push_word(8'hD0 + 8'(k), 1'b0, k == 4);
        refresh();
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_beat", {22'd0, out_data, out_sop, out_eop}, 32'd0);
        chk("mr_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        fq.delete();
        exp_q.delete();
        pop_idx = 0;
        acc_idx = 0;
        pkt_exp = 16'd0;
        refresh();
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_word(8'h01, 1'b1, 1'b0);
        push_word(8'hE0, 1'b0, 1'b1);
        refresh();
        tick(4);
        chk("mr_after_pkt", {16'd0, pkt_cnt}, 32'd1);

        // Randomized traffic with backpressure, en gating and FIFO gaps
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < 24 && $urandom_range(0, 2) == 0) push_pkt($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            hold      = ($urandom_range(0, 5) == 0);
            refresh();
            tick(1);
        end
        drain("rand_drain");
        chk("rand_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, pkt_exp});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
